// File: rtl/mem_db_ctrl.sv
// Ping-pong controller for a two-bank double-buffer RAM: a producer stream fills
// one bank while the filled bank is read out through a 2-entry output buffer.
module mem_db_ctrl #(
    parameter int unsigned DATA_BIT = 64,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_BIT = $clog2(DEPTH),
    parameter int unsigned TILE_LEN = DEPTH
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_in_vld,
    output logic                o_in_rdy,
    input  logic [DATA_BIT-1:0] i_in_data,
    output logic                o_out_vld,
    input  logic                i_out_rdy,
    output logic [DATA_BIT-1:0] o_out_data,
    output logic                o_out_last,
    output logic                o_mem_sw,
    output logic [ADDR_BIT-1:0] o_mem_waddr,
    output logic                o_mem_wen,
    output logic [DATA_BIT-1:0] o_mem_wdata,
    output logic [ADDR_BIT-1:0] o_mem_raddr,
    output logic                o_mem_ren,
    input  logic [DATA_BIT-1:0] i_mem_rdata,
    output logic                o_wr_full,
    output logic                o_rd_busy
);

    localparam logic [ADDR_BIT-1:0] L_TILE_LAST = ADDR_BIT'(TILE_LEN - 1);

    logic                r_sw;
    logic [ADDR_BIT-1:0] r_wr_cnt;
    logic [ADDR_BIT-1:0] r_rd_cnt;
    logic                r_wr_full;
    logic                r_rd_busy;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [1:0]          r_occ;
    logic                r_head;
    logic [DATA_BIT-1:0] r_buf_data [2];
    logic                r_buf_last [2];

    logic                w_wr_acc;
    logic                w_swap;
    logic                w_pop;
    logic                w_ren;
    logic [1:0]          w_level;
    logic                w_tail;

    // Handshakes, read credit and buffer tail slot
    always_comb begin
        w_wr_acc = i_in_vld && !r_wr_full;
        w_swap   = r_wr_full && !r_rd_busy;
        w_pop    = (r_occ != 2'd0) && i_out_rdy;
        // Entries that will be held after this cycle if nothing new is issued
        w_level  = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        w_ren    = r_rd_busy && (w_level < 2'd2);
        // With occ==2 the tail aliases the head, which is only legal alongside a pop
        w_tail   = r_head ^ r_occ[0];
    end

    assign o_in_rdy    = !r_wr_full;
    assign o_mem_wen   = w_wr_acc;
    assign o_mem_waddr = r_wr_cnt;
    assign o_mem_wdata = i_in_data;
    assign o_mem_ren   = w_ren;
    assign o_mem_raddr = r_rd_cnt;
    assign o_mem_sw    = r_sw;
    assign o_wr_full   = r_wr_full;
    assign o_rd_busy   = r_rd_busy;
    assign o_out_vld   = (r_occ != 2'd0);
    assign o_out_data  = r_buf_data[r_head];
    assign o_out_last  = (r_occ != 2'd0) && r_buf_last[r_head];

    // Bank sequencing, counters and output-buffer occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sw            <= 1'b0;
            r_wr_cnt        <= '0;
            r_rd_cnt        <= '0;
            r_wr_full       <= 1'b0;
            r_rd_busy       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_occ           <= 2'd0;
            r_head          <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                if (r_wr_cnt == L_TILE_LAST) begin
                    r_wr_cnt  <= '0;
                    r_wr_full <= 1'b1;
                end else begin
                    r_wr_cnt <= r_wr_cnt + ADDR_BIT'(1);
                end
            end
            // Swap needs wr_full=1 so it never coincides with an accepted write,
            // and rd_busy=0 so it never coincides with a read issue
            if (w_swap) begin
                r_sw      <= ~r_sw;
                r_wr_full <= 1'b0;
                r_rd_busy <= 1'b1;
                r_rd_cnt  <= '0;
            end
            if (w_ren) begin
                if (r_rd_cnt == L_TILE_LAST) begin
                    r_rd_cnt  <= '0;
                    r_rd_busy <= 1'b0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + ADDR_BIT'(1);
                end
            end
            r_inflight      <= w_ren;
            r_inflight_last <= w_ren && (r_rd_cnt == L_TILE_LAST);
            if (r_inflight && !w_pop) begin
                r_occ <= r_occ + 2'd1;
            end else if (!r_inflight && w_pop) begin
                r_occ <= r_occ - 2'd1;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    // Capture returning read data; occupancy alone decides validity
    always_ff @(posedge i_clk) begin
        if (r_inflight) begin
            r_buf_data[w_tail] <= i_mem_rdata;
            r_buf_last[w_tail] <= r_inflight_last;
        end
    end

endmodule

// File: tb/tb_mem_db_ctrl.sv
// Directed bench for mem_db_ctrl: one instance with TILE_LEN=4, one with TILE_LEN=1,
// each backed by a behavioural two-bank RAM with a registered read.
module tb_mem_db_ctrl;

    localparam int DW  = 64;
    localparam int DEP = 16;
    localparam int AW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          in_vld4, in_rdy4, out_vld4, out_rdy4, out_last4, sw4, wen4, ren4;
    logic          wr_full4, rd_busy4;
    logic [DW-1:0] in_data4, out_data4, wdata4, rdata4;
    logic [AW-1:0] waddr4, raddr4;

    logic          in_vld1, in_rdy1, out_vld1, out_rdy1, out_last1, sw1, wen1, ren1;
    logic          wr_full1, rd_busy1;
    logic [DW-1:0] in_data1, out_data1, wdata1, rdata1;
    logic [AW-1:0] waddr1, raddr1;

    mem_db_ctrl #(.DATA_BIT(DW), .DEPTH(DEP), .ADDR_BIT(AW), .TILE_LEN(4)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_in_vld(in_vld4), .o_in_rdy(in_rdy4), .i_in_data(in_data4),
        .o_out_vld(out_vld4), .i_out_rdy(out_rdy4), .o_out_data(out_data4),
        .o_out_last(out_last4), .o_mem_sw(sw4), .o_mem_waddr(waddr4), .o_mem_wen(wen4),
        .o_mem_wdata(wdata4), .o_mem_raddr(raddr4), .o_mem_ren(ren4),
        .i_mem_rdata(rdata4), .o_wr_full(wr_full4), .o_rd_busy(rd_busy4)
    );

    mem_db_ctrl #(.DATA_BIT(DW), .DEPTH(DEP), .ADDR_BIT(AW), .TILE_LEN(1)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_in_vld(in_vld1), .o_in_rdy(in_rdy1), .i_in_data(in_data1),
        .o_out_vld(out_vld1), .i_out_rdy(out_rdy1), .o_out_data(out_data1),
        .o_out_last(out_last1), .o_mem_sw(sw1), .o_mem_waddr(waddr1), .o_mem_wen(wen1),
        .o_mem_wdata(wdata1), .o_mem_raddr(raddr1), .o_mem_ren(ren1),
        .i_mem_rdata(rdata1), .o_wr_full(wr_full1), .o_rd_busy(rd_busy1)
    );

    // sw=1: bank0 written, bank1 read; read select is captured with the address
    logic [DW-1:0] ram4 [2][DEP];
    logic [DW-1:0] ram1 [2][DEP];
    always @(posedge clk) begin
        if (wen4) ram4[sw4 ? 0 : 1][waddr4] <= wdata4;
        if (ren4) rdata4 <= ram4[sw4 ? 1 : 0][raddr4];
        if (wen1) ram1[sw1 ? 0 : 1][waddr1] <= wdata1;
        if (ren1) rdata1 <= ram1[sw1 ? 1 : 0][raddr1];
    end

    // View of whichever instance is under test
    logic          sel;
    logic          s_in_rdy, s_out_vld, s_out_last, s_sw, s_wen, s_ren, s_wr_full, s_rd_busy;
    logic [DW-1:0] s_out_data, s_wdata;
    logic [AW-1:0] s_waddr, s_raddr;
    always_comb begin
        s_in_rdy   = sel ? in_rdy1   : in_rdy4;
        s_out_vld  = sel ? out_vld1  : out_vld4;
        s_out_last = sel ? out_last1 : out_last4;
        s_sw       = sel ? sw1       : sw4;
        s_wen      = sel ? wen1      : wen4;
        s_ren      = sel ? ren1      : ren4;
        s_wr_full  = sel ? wr_full1  : wr_full4;
        s_rd_busy  = sel ? rd_busy1  : rd_busy4;
        s_out_data = sel ? out_data1 : out_data4;
        s_wdata    = sel ? wdata1    : wdata4;
        s_waddr    = sel ? waddr1    : waddr4;
        s_raddr    = sel ? raddr1    : raddr4;
    end

    int            errors = 0;
    int            checks = 0;
    int            tl = 4;
    int            acc_cnt = 0;
    int            sw_toggles = 0;
    logic          prev_sw = 1'b0;
    logic          stalled = 1'b0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] exp_d [$];
    logic          exp_l [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, then sample and score the handshakes of this cycle
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        if (sel) begin
            in_vld1 = v; in_data1 = d; out_rdy1 = r;
        end else begin
            in_vld4 = v; in_data4 = d; out_rdy4 = r;
        end
        #1;
        if (s_sw !== prev_sw) sw_toggles++;
        prev_sw = s_sw;
        if (stalled) begin
            chk("stall_vld", s_out_vld, 1);
            chk("stall_data", s_out_data, held);
        end
        if (v && s_in_rdy) begin
            exp_d.push_back(d);
            exp_l.push_back((acc_cnt % tl) == tl - 1);
            acc_cnt++;
        end
        if (s_out_vld && r) begin
            if (exp_d.size() == 0) begin
                chk("spurious_out", s_out_vld, 0);
            end else begin
                chk("out_data", s_out_data, exp_d.pop_front());
                chk("out_last", s_out_last, exp_l.pop_front());
            end
        end
        stalled = s_out_vld && !r;
        held    = s_out_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_vld4 = 1'b0; out_rdy4 = 1'b0; in_vld1 = 1'b0; out_rdy1 = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_in_rdy", s_in_rdy, 1);
        chk("rst_out_vld", s_out_vld, 0);
        chk("rst_out_last", s_out_last, 0);
        chk("rst_wen", s_wen, 0);
        chk("rst_ren", s_ren, 0);
        chk("rst_sw", s_sw, 0);
        chk("rst_wr_full", s_wr_full, 0);
        chk("rst_rd_busy", s_rd_busy, 0);
        rst = 1'b0;
        exp_d.delete();
        exp_l.delete();
        acc_cnt    = 0;
        sw_toggles = 0;
        prev_sw    = 1'b0;
        stalled    = 1'b0;
    endtask

    // Push n words with in_vld held high; rmode 0: out_rdy=0, 1: out_rdy=1, 2: random
    task automatic push_words(input logic [DW-1:0] base, input int n, input int rmode);
        int   i = 0;
        int   guard = 0;
        logic r;
        logic [DW-1:0] w;
        while (i < n && guard < 2000) begin
            r = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
            w = base + DW'((i / tl) * 16 + (i % tl));
            tick(1'b1, w, r);
            if (s_in_rdy) i++;
            guard++;
        end
        chk("push_count", i, n);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_d.size() != 0 && k < budget) begin
            tick(1'b0, '0, 1'b1);
            k++;
        end
        chk("drain_empty", exp_d.size(), 0);
    endtask

    initial begin
        int t_iss;
        int t_sw;
        logic sw_start;
        sel = 1'b0;
        rst = 1'b1;
        in_vld4 = 1'b0; out_rdy4 = 1'b0; in_data4 = '0;
        in_vld1 = 1'b0; out_rdy1 = 1'b0; in_data1 = '0;

        // Single tile, swap timing and first-output latency
        do_reset();
        tick(1'b1, 64'hA0, 1'b1);
        chk("t1_wen", s_wen, 1);
        chk("t1_waddr", s_waddr, 0);
        chk("t1_wdata", s_wdata, 64'hA0);
        tick(1'b1, 64'hA1, 1'b1);
        tick(1'b1, 64'hA2, 1'b1);
        tick(1'b1, 64'hA3, 1'b1);
        chk("t1_waddr_last", s_waddr, 3);
        tick(1'b0, '0, 1'b1);
        chk("t1_swap_wr_full", s_wr_full, 1);
        chk("t1_swap_in_rdy", s_in_rdy, 0);
        chk("t1_swap_sw", s_sw, 0);
        tick(1'b0, '0, 1'b1);
        chk("t1_sw_after", s_sw, 1);
        chk("t1_rd_busy", s_rd_busy, 1);
        chk("t1_ren", s_ren, 1);
        chk("t1_raddr", s_raddr, 0);
        chk("t1_vld_s1", s_out_vld, 0);
        tick(1'b0, '0, 1'b1);
        chk("t1_vld_s2", s_out_vld, 0);
        tick(1'b0, '0, 1'b1);
        chk("t1_vld_s3", s_out_vld, 1);
        drain(20);
        chk("t1_idle_busy", s_rd_busy, 0);

        // Three back-to-back tiles
        do_reset();
        push_words(64'hB0, 12, 1);
        drain(40);
        chk("t2_toggles", sw_toggles, 3);
        chk("t2_sw_final", s_sw, 1);

        // Two tiles under full backpressure, then release
        push_words(64'h10, 8, 0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        chk("t3_wr_full", s_wr_full, 1);
        chk("t3_in_rdy", s_in_rdy, 0);
        chk("t3_rd_busy", s_rd_busy, 1);
        chk("t3_ren", s_ren, 0);
        chk("t3_out_vld", s_out_vld, 1);
        t_iss = -1;
        t_sw = -1;
        sw_start = s_sw;
        for (int k = 0; k < 40; k++) begin
            tick(1'b0, '0, 1'b1);
            if (t_iss < 0 && s_ren && s_raddr == AW'(3)) t_iss = k;
            if (t_sw < 0 && s_sw !== sw_start) t_sw = k;
        end
        chk("t3_swap_gap", t_sw - t_iss, 2);
        chk("t3_drained", exp_d.size(), 0);

        // Random backpressure over eight tiles
        push_words(64'h200, 32, 2);
        drain(100);

        // Reset with a partly written tile and a read in flight
        push_words(64'h300, 4, 0);
        tick(1'b0, '0, 1'b0);
        push_words(64'h400, 2, 0);
        chk("t5_ren_live", s_ren, 1);
        stalled = 1'b0;
        do_reset();
        push_words(64'hE0, 4, 1);
        drain(20);

        // TILE_LEN=1: every word is its own tile
        sel = 1'b1;
        tl  = 1;
        do_reset();
        push_words(64'h500, 6, 1);
        drain(30);
        chk("t6_toggles", sw_toggles, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
